// File: rtl/ysyx22041405_mem_arbiter_pkg.sv
// Shared types for the IFU/LSU data-memory arbiter: FSM and owner encodings
// plus the width of the latched memory request bundle.
package ysyx22041405_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_REQ  = 2'd1,
        ARB_WAIT = 2'd2
    } arb_state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IFU  = 2'd1,
        OWN_LSU  = 2'd2
    } owner_t;

    // Request bundle layout: {addr, we, wdata, wmask}
    function automatic int mem_req_w(input int width, input int mask_w);
        return width * 2 + mask_w + 1;
    endfunction

endpackage

// File: rtl/ysyx22041405_mem_arbiter_if.sv
// Bundle of the IFU, LSU and memory-side signals around the arbiter.
// Handshake: a request transfers on the cycle where valid && ready are both high;
// the requester holds valid and payload stable until then. Responses are 1-cycle
// pulses with no backpressure.
interface ysyx22041405_mem_arbiter_if #(
    parameter int WIDTH  = 32,
    parameter int MASK_W = 8
);
    logic              ifu_req_valid;
    logic              ifu_req_ready;
    logic [WIDTH-1:0]  ifu_addr;
    logic              ifu_rsp_valid;
    logic [WIDTH-1:0]  ifu_rdata;

    logic              lsu_req_valid;
    logic              lsu_req_ready;
    logic [WIDTH-1:0]  lsu_addr;
    logic              lsu_we;
    logic [WIDTH-1:0]  lsu_wdata;
    logic [MASK_W-1:0] lsu_wmask;
    logic              lsu_rsp_valid;
    logic [WIDTH-1:0]  lsu_rdata;

    logic              mem_req_valid;
    logic              mem_req_ready;
    logic [WIDTH-1:0]  mem_addr;
    logic              mem_we;
    logic [WIDTH-1:0]  mem_wdata;
    logic [MASK_W-1:0] mem_wmask;
    logic              mem_rsp_valid;
    logic [WIDTH-1:0]  mem_rdata;

    // The arbiter masters the memory port and serves both requesters
    modport master (
        input  ifu_req_valid, ifu_addr,
        input  lsu_req_valid, lsu_addr, lsu_we, lsu_wdata, lsu_wmask,
        input  mem_req_ready, mem_rsp_valid, mem_rdata,
        output ifu_req_ready, ifu_rsp_valid, ifu_rdata,
        output lsu_req_ready, lsu_rsp_valid, lsu_rdata,
        output mem_req_valid, mem_addr, mem_we, mem_wdata, mem_wmask
    );

    modport slave (
        output ifu_req_valid, ifu_addr,
        output lsu_req_valid, lsu_addr, lsu_we, lsu_wdata, lsu_wmask,
        output mem_req_ready, mem_rsp_valid, mem_rdata,
        input  ifu_req_ready, ifu_rsp_valid, ifu_rdata,
        input  lsu_req_ready, lsu_rsp_valid, lsu_rdata,
        input  mem_req_valid, mem_addr, mem_we, mem_wdata, mem_wmask
    );

endinterface

// File: rtl/ysyx22041405_arb_prio.sv
// Grant selection for the arbiter: LSU-first priority with a starvation counter
// that forces an IFU win after STARVE_LIMIT LSU grants while the IFU waited.
module ysyx22041405_arb_prio #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic ifu_valid,
    input  logic lsu_valid,
    input  logic idle,
    output logic grant_ifu,
    output logic grant_lsu
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] starve_cnt;
    logic             starved;

    always_comb begin
        starved   = (starve_cnt == LIMIT);
        grant_ifu = idle && ifu_valid && (!lsu_valid || starved);
        grant_lsu = idle && lsu_valid && !grant_ifu;
    end

    // Saturates at LIMIT; an LSU grant with no fetch waiting leaves it alone
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt <= '0;
        end else if (grant_ifu) begin
            starve_cnt <= '0;
        end else if (grant_lsu && ifu_valid && !starved) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/ysyx22041405_mem_arbiter.sv
// Shares one data-memory port between instruction fetch and load/store with a
// single outstanding transaction; holds the FSM, request latch and response routing.
module ysyx22041405_mem_arbiter
    import ysyx22041405_mem_arbiter_pkg::*;
#(
    parameter int WIDTH        = 32,
    parameter int MASK_W       = 8,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    ysyx22041405_mem_arbiter_if.master        bus,
    output arb_state_t                        dbg_state
);

    localparam int REQ_W = mem_req_w(WIDTH, MASK_W);

    arb_state_t       state, state_nxt;
    owner_t           owner, owner_nxt;
    logic [REQ_W-1:0] req_q, req_nxt;
    logic             idle;
    logic             grant_ifu, grant_lsu;
    logic             complete;

    // Gating with rst keeps both ready outputs low while reset is asserted
    assign idle = (state == ARB_IDLE) && rst;

    ysyx22041405_arb_prio #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_prio (
        .clk       (clk),
        .rst       (rst),
        .ifu_valid (bus.ifu_req_valid),
        .lsu_valid (bus.lsu_req_valid),
        .idle      (idle),
        .grant_ifu (grant_ifu),
        .grant_lsu (grant_lsu)
    );

    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        req_nxt   = req_q;
        complete  = 1'b0;
        case (state)
            ARB_IDLE: begin
                if (grant_lsu) begin
                    req_nxt   = {bus.lsu_addr, bus.lsu_we, bus.lsu_wdata, bus.lsu_wmask};
                    owner_nxt = OWN_LSU;
                    state_nxt = ARB_REQ;
                end else if (grant_ifu) begin
                    req_nxt   = {bus.ifu_addr, 1'b0, {WIDTH{1'b0}}, {MASK_W{1'b0}}};
                    owner_nxt = OWN_IFU;
                    state_nxt = ARB_REQ;
                end
            end
            ARB_REQ: begin
                // A response in the accepting cycle completes without visiting WAIT
                if (bus.mem_req_ready) begin
                    if (bus.mem_rsp_valid) begin
                        complete  = 1'b1;
                        owner_nxt = OWN_NONE;
                        state_nxt = ARB_IDLE;
                    end else begin
                        state_nxt = ARB_WAIT;
                    end
                end
            end
            ARB_WAIT: begin
                if (bus.mem_rsp_valid) begin
                    complete  = 1'b1;
                    owner_nxt = OWN_NONE;
                    state_nxt = ARB_IDLE;
                end
            end
            default: begin
                owner_nxt = OWN_NONE;
                state_nxt = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ARB_IDLE;
            owner <= OWN_NONE;
            req_q <= '0;
        end else begin
            state <= state_nxt;
            owner <= owner_nxt;
            req_q <= req_nxt;
        end
    end

    assign bus.ifu_req_ready = grant_ifu;
    assign bus.lsu_req_ready = grant_lsu;

    assign bus.mem_req_valid = (state == ARB_REQ);
    assign {bus.mem_addr, bus.mem_we, bus.mem_wdata, bus.mem_wmask} = req_q;

    // Read data is zeroed outside the owner's pulse so idle outputs stay quiet
    assign bus.ifu_rsp_valid = complete && (owner == OWN_IFU);
    assign bus.lsu_rsp_valid = complete && (owner == OWN_LSU);
    assign bus.ifu_rdata     = bus.ifu_rsp_valid ? bus.mem_rdata : '0;
    assign bus.lsu_rdata     = bus.lsu_rsp_valid ? bus.mem_rdata : '0;

    assign dbg_state = state;

endmodule

// File: tb/tb_ysyx22041405_mem_arbiter.sv
// Randomized scoreboard bench for the IFU/LSU memory arbiter with a behavioural
// memory, a reference memory and a high-level grant/transaction model.
module tb_ysyx22041405_mem_arbiter;
    import ysyx22041405_mem_arbiter_pkg::*;

    localparam int WIDTH        = 32;
    localparam int MASK_W       = 8;
    localparam int STARVE_LIMIT = 4;
    localparam int REQ_W        = WIDTH * 2 + MASK_W + 1;
    localparam int RSP_W        = WIDTH + 2;
    localparam logic [WIDTH-1:0] BASE = 32'h8000_0000;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    arb_state_t dbg_state;

    always #5 clk = ~clk;

    ysyx22041405_mem_arbiter_if #(.WIDTH(WIDTH), .MASK_W(MASK_W)) bus ();

    ysyx22041405_mem_arbiter #(
        .WIDTH        (WIDTH),
        .MASK_W       (MASK_W),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus.master),
        .dbg_state (dbg_state)
    );

    // ---------------- bookkeeping ----------------
    int vectors    = 0;
    int miscompares = 0;

    int rdy_min = 0, rdy_max = 0, lat_min = 0, lat_max = 0;
    int spur_pct = 0, ifu_rate = 100, lsu_rate = 100;

    logic [WIDTH-1:0] ifu_cmd_q[$];
    logic [REQ_W-1:0] lsu_cmd_q[$];
    logic [REQ_W-1:0] mem_exp_q[$];
    logic [RSP_W-1:0] exp_q[$];
    bit               grant_log[$];

    logic [WIDTH-1:0] mem_arr[16];
    logic [WIDTH-1:0] ref_mem[16];

    bit busy = 0, mem_acc = 0, own_ifu = 0;
    bit ifu_acc = 0, lsu_acc = 0;
    int starve = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ifu_req_ready"}, bus.ifu_req_ready, 0);
        check({tag, "_lsu_req_ready"}, bus.lsu_req_ready, 0);
        check({tag, "_ifu_rsp_valid"}, bus.ifu_rsp_valid, 0);
        check({tag, "_lsu_rsp_valid"}, bus.lsu_rsp_valid, 0);
        check({tag, "_ifu_rdata"},     bus.ifu_rdata, 0);
        check({tag, "_lsu_rdata"},     bus.lsu_rdata, 0);
        check({tag, "_mem_req_valid"}, bus.mem_req_valid, 0);
        check({tag, "_mem_addr"},      bus.mem_addr, 0);
        check({tag, "_mem_we"},        bus.mem_we, 0);
        check({tag, "_mem_wdata"},     bus.mem_wdata, 0);
        check({tag, "_mem_wmask"},     bus.mem_wmask, 0);
        check({tag, "_state"},         dbg_state, ARB_IDLE);
    endtask

    // ---------------- driver processes ----------------
    initial begin : ifu_drv
        forever begin
            @(posedge clk); #1;
            if (ifu_acc) begin
                bus.ifu_req_valid = 1'b0;
                ifu_acc = 0;
            end
            if (!bus.ifu_req_valid && rst && ifu_cmd_q.size() != 0 &&
                $urandom_range(99, 0) < ifu_rate) begin
                bus.ifu_addr      = ifu_cmd_q.pop_front();
                bus.ifu_req_valid = 1'b1;
            end
        end
    end

    initial begin : lsu_drv
        forever begin
            @(posedge clk); #1;
            if (lsu_acc) begin
                bus.lsu_req_valid = 1'b0;
                lsu_acc = 0;
            end
            if (!bus.lsu_req_valid && rst && lsu_cmd_q.size() != 0 &&
                $urandom_range(99, 0) < lsu_rate) begin
                {bus.lsu_addr, bus.lsu_we, bus.lsu_wdata, bus.lsu_wmask} = lsu_cmd_q.pop_front();
                bus.lsu_req_valid = 1'b1;
            end
        end
    end

    // Behavioural memory: random accept stall, random response latency, spurious pulses
    initial begin : mem_model
        bit               stalling = 0, pending = 0;
        int               cnt = 0, lat;
        logic [WIDTH-1:0] data = '0;
        forever begin
            @(posedge clk); #1;
            bus.mem_req_ready = 1'b0;
            bus.mem_rsp_valid = 1'b0;
            bus.mem_rdata     = $urandom;
            if (pending) begin
                if (cnt == 0) begin
                    bus.mem_rsp_valid = 1'b1;
                    bus.mem_rdata     = data;
                    pending = 0;
                end else begin
                    cnt--;
                end
            end else if (bus.mem_req_valid) begin
                if (!stalling) begin
                    stalling = 1;
                    cnt = $urandom_range(rdy_max, rdy_min);
                end
                if (cnt == 0) begin
                    bus.mem_req_ready = 1'b1;
                    stalling = 0;
                    if (bus.mem_we) begin
                        for (int b = 0; b < WIDTH / 8; b++)
                            if (bus.mem_wmask[b])
                                mem_arr[bus.mem_addr[5:2]][8*b +: 8] = bus.mem_wdata[8*b +: 8];
                        data = $urandom;
                    end else begin
                        data = mem_arr[bus.mem_addr[5:2]];
                    end
                    lat = $urandom_range(lat_max, lat_min);
                    if (lat == 0) begin
                        bus.mem_rsp_valid = 1'b1;
                        bus.mem_rdata     = data;
                    end else begin
                        pending = 1;
                        cnt = lat - 1;
                    end
                end else begin
                    cnt--;
                    if ($urandom_range(99, 0) < spur_pct) bus.mem_rsp_valid = 1'b1;
                end
            end else begin
                stalling = 0;
                if ($urandom_range(99, 0) < spur_pct) bus.mem_rsp_valid = 1'b1;
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    task automatic monitor_cycle();
        bit               exp_ifu_rdy, exp_lsu_rdy, done;
        logic [RSP_W-1:0] e;
        logic [REQ_W-1:0] m;
        int               idx;

        check("state", dbg_state, !busy ? ARB_IDLE : (mem_acc ? ARB_WAIT : ARB_REQ));

        exp_ifu_rdy = 0;
        exp_lsu_rdy = 0;
        if (!busy) begin
            if (bus.ifu_req_valid && (!bus.lsu_req_valid || starve == STARVE_LIMIT))
                exp_ifu_rdy = 1;
            else if (bus.lsu_req_valid)
                exp_lsu_rdy = 1;
        end
        check("ifu_req_ready", bus.ifu_req_ready, exp_ifu_rdy);
        check("lsu_req_ready", bus.lsu_req_ready, exp_lsu_rdy);

        check("mem_req_valid", bus.mem_req_valid, busy && !mem_acc);
        if (bus.mem_req_valid && mem_exp_q.size() != 0) begin
            m = mem_exp_q[0];
            check("mem_addr",  bus.mem_addr,  m[REQ_W-1 -: WIDTH]);
            check("mem_we",    bus.mem_we,    m[WIDTH+MASK_W]);
            check("mem_wmask", bus.mem_wmask, m[MASK_W-1:0]);
            if (m[WIDTH+MASK_W]) check("mem_wdata", bus.mem_wdata, m[WIDTH+MASK_W-1:MASK_W]);
            if (bus.mem_req_ready) void'(mem_exp_q.pop_front());
        end

        done = busy && bus.mem_rsp_valid && (mem_acc || bus.mem_req_ready);
        check("ifu_rsp_valid", bus.ifu_rsp_valid, done && own_ifu);
        check("lsu_rsp_valid", bus.lsu_rsp_valid, done && !own_ifu);
        if ((bus.ifu_rsp_valid || bus.lsu_rsp_valid) && exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("rsp_owner", bus.ifu_rsp_valid, e[RSP_W-1]);
            if (!e[RSP_W-2] && e[RSP_W-1])  check("ifu_rdata", bus.ifu_rdata, e[WIDTH-1:0]);
            if (!e[RSP_W-2] && !e[RSP_W-1]) check("lsu_rdata", bus.lsu_rdata, e[WIDTH-1:0]);
        end
        if (done) begin
            busy    = 0;
            mem_acc = 0;
        end else if (busy && !mem_acc && bus.mem_req_ready) begin
            mem_acc = 1;
        end

        if (exp_ifu_rdy && bus.ifu_req_ready) begin
            idx = int'(bus.ifu_addr[5:2]);
            mem_exp_q.push_back({bus.ifu_addr, 1'b0, {WIDTH{1'b0}}, {MASK_W{1'b0}}});
            exp_q.push_back({1'b1, 1'b0, ref_mem[idx]});
            grant_log.push_back(1'b1);
            busy = 1; own_ifu = 1; starve = 0; ifu_acc = 1;
        end else if (exp_lsu_rdy && bus.lsu_req_ready) begin
            idx = int'(bus.lsu_addr[5:2]);
            mem_exp_q.push_back({bus.lsu_addr, bus.lsu_we, bus.lsu_wdata, bus.lsu_wmask});
            if (bus.lsu_we) begin
                for (int b = 0; b < WIDTH / 8; b++)
                    if (bus.lsu_wmask[b]) ref_mem[idx][8*b +: 8] = bus.lsu_wdata[8*b +: 8];
                exp_q.push_back({1'b0, 1'b1, {WIDTH{1'b0}}});
            end else begin
                exp_q.push_back({1'b0, 1'b0, ref_mem[idx]});
            end
            if (bus.ifu_req_valid && starve < STARVE_LIMIT) starve++;
            grant_log.push_back(1'b0);
            busy = 1; own_ifu = 0; lsu_acc = 1;
        end
    endtask

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (!rst) begin
                busy = 0; mem_acc = 0; starve = 0;
                ifu_acc = 0; lsu_acc = 0;
                exp_q.delete();
                mem_exp_q.delete();
            end else begin
                monitor_cycle();
            end
        end
    end

    // ---------------- phase helpers ----------------
    task automatic set_mem(input int rmin, input int rmax, input int lmin, input int lmax, input int spur);
        rdy_min = rmin; rdy_max = rmax; lat_min = lmin; lat_max = lmax; spur_pct = spur;
    endtask

    task automatic drain(input string name, input int budget);
        int n = 0;
        while ((ifu_cmd_q.size() != 0 || lsu_cmd_q.size() != 0 || bus.ifu_req_valid ||
                bus.lsu_req_valid || busy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({name, "_drained"}, n < budget, 1);
        repeat (2) @(negedge clk);
    endtask

    function automatic logic [WIDTH-1:0] rand_addr();
        return BASE | {26'd0, 4'($urandom_range(15, 0)), 2'b00};
    endfunction

    function automatic logic [REQ_W-1:0] rand_lsu();
        return {rand_addr(), 1'($urandom_range(1, 0)), 32'($urandom), 8'($urandom_range(255, 0))};
    endfunction

    // ---------------- main sequence ----------------
    initial begin : main
        logic [WIDTH-1:0] v;
        bit               late_seen;

        bus.ifu_req_valid = 1'b0; bus.ifu_addr = '0;
        bus.lsu_req_valid = 1'b0; bus.lsu_addr = '0; bus.lsu_we = 1'b0;
        bus.lsu_wdata = '0; bus.lsu_wmask = '0;
        bus.mem_req_ready = 1'b0; bus.mem_rsp_valid = 1'b0; bus.mem_rdata = '0;
        for (int i = 0; i < 16; i++) begin
            v = $urandom;
            mem_arr[i] = v;
            ref_mem[i] = v;
        end
        mem_arr[0] = 32'h0010_0073; ref_mem[0] = 32'h0010_0073;
        mem_arr[3] = 32'h1234_5678; ref_mem[3] = 32'h1234_5678;

        repeat (2) @(posedge clk);
        #2 check_all_zero("reset");
        @(posedge clk); #3 rst = 1'b1;

        // lone fetch: accepted on the first REQ cycle, response two cycles later
        set_mem(0, 0, 2, 2, 0);
        ifu_cmd_q.push_back(BASE);
        drain("lone_fetch", 50);

        // store stalled three cycles with spurious pulses during the stall, then read back
        set_mem(3, 3, 1, 1, 50);
        lsu_cmd_q.push_back({32'h8000_1000, 1'b1, 32'hDEAD_BEEF, 8'h0F});
        drain("store", 50);
        set_mem(0, 0, 1, 1, 0);
        ifu_cmd_q.push_back(32'h8000_1000);
        drain("store_readback", 50);

        // spurious responses with nothing pending
        set_mem(0, 0, 0, 0, 100);
        repeat (10) @(negedge clk);

        // zero-latency load
        set_mem(0, 0, 0, 0, 0);
        lsu_cmd_q.push_back({32'h8000_000C, 1'b0, 32'h0, 8'h0});
        drain("zero_latency", 50);

        // contention with continuous requests and zero-latency memory
        grant_log.delete();
        for (int i = 0; i < 12; i++) ifu_cmd_q.push_back(rand_addr());
        for (int i = 0; i < 24; i++) lsu_cmd_q.push_back(rand_lsu());
        drain("contention", 500);
        check("grant_log_len", grant_log.size() >= 10, 1);
        for (int i = 0; i < 10; i++)
            if (i < grant_log.size())
                check($sformatf("grant_order[%0d]", i), grant_log[i], (i % 5) == 4);

        // randomized mixed traffic
        set_mem(0, 3, 0, 4, 20);
        ifu_rate = 40; lsu_rate = 40;
        for (int i = 0; i < 60; i++) ifu_cmd_q.push_back(rand_addr());
        for (int i = 0; i < 60; i++) lsu_cmd_q.push_back(rand_lsu());
        drain("random", 4000);
        check("exp_q_empty", exp_q.size(), 0);
        check("mem_exp_q_empty", mem_exp_q.size(), 0);

        // asynchronous reset while waiting for a slow response
        ifu_rate = 100; lsu_rate = 100;
        set_mem(0, 0, 8, 8, 0);
        lsu_cmd_q.push_back({32'h8000_0010, 1'b0, 32'h0, 8'h0});
        begin
            int n = 0;
            while (!mem_acc && n < 50) begin
                @(negedge clk);
                n++;
            end
            check("reach_wait", mem_acc, 1);
        end
        @(posedge clk); #3;
        rst = 1'b0;
        bus.ifu_req_valid = 1'b1;
        bus.lsu_req_valid = 1'b1;
        #1 check_all_zero("async_rst");
        repeat (2) @(posedge clk);
        #3;
        bus.ifu_req_valid = 1'b0;
        bus.lsu_req_valid = 1'b0;
        @(posedge clk); #3 rst = 1'b1;
        late_seen = 0;
        repeat (12) begin
            @(negedge clk);
            late_seen |= bus.mem_rsp_valid;
        end
        check("late_rsp_driven", late_seen, 1);
        check("post_rst_exp_q", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: time limit reached, %0d vectors, %0d miscompares", vectors, miscompares);
        $fatal(1, "watchdog");
    end

endmodule
